// File: rtl/sync_model_pkg.sv
// Shared types and helpers for the synchronous excitation-tracking core.
//   sig_kind_e : role of a tracked signal (circuit input, gate output, latch output)
//   fire_idle  : fire-index code that requests no transition for an N-signal core
//   popcount   : number of set bits in a vector of up to MaxSig bits
package sync_model_pkg;

  typedef enum logic [1:0] {SIG_INPUT, SIG_GATE, SIG_LATCH} sig_kind_e;

  localparam int unsigned MaxSig = 64;

  function automatic int unsigned fire_idle(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned popcount(input logic [MaxSig-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(MaxSig); i++) begin
      c += {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_signal_cell.sv
// One tracked signal: value flop with enable plus its hazard-arm flop.
//   clk, reset : clock, asynchronous active-high reset
//   ena, d     : load d into the value flop when ena is high
//   arm_d, clr : next arm state; clr forces arm low (synchronous)
//   q, arm     : current value and arm state
module sync_signal_cell #(
  parameter logic INIT_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic d,
  input  logic arm_d,
  input  logic clr,
  output logic q,
  output logic arm
);

  logic q_q;
  logic arm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= INIT_VAL;
    end else if (ena) begin
      q_q <= d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q <= 1'b0;
    end else if (clr) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
    end
  end

  assign q   = q_q;
  assign arm = arm_q;

endmodule

// File: rtl/sync_excitation_tracker.sv
// State core for synchronous models of asynchronous circuits. Holds every signal value,
// derives excitation against the gate network, applies fire commands and monitors the run.
//   clk, reset  : clock, asynchronous active-high reset
//   fire        : index to fire (MULTI_FIRE=0), >= N_SIG is idle
//   fire_mask   : signals to fire (MULTI_FIRE=1)
//   precap      : next values from the gate/latch network (input bits ignored)
//   in_en       : environment permits input i to toggle
//   clr_flags   : synchronous clear of hazard, deadlock, counter, arm and quiet state
//   q, excited  : signal values and combinational excitation
//   hazard, hazard_idx, illegal, deadlock, tcount : run monitors
module sync_excitation_tracker
  import sync_model_pkg::*;
#(
  parameter int unsigned       N_SIG      = 8,
  parameter int unsigned       N_IN       = 2,
  parameter logic [N_SIG-1:0]  INIT       = '0,
  parameter bit                MULTI_FIRE = 1'b0,
  parameter int unsigned       DL_CYCLES  = 4,
  parameter int unsigned       CNT_W      = 16,
  localparam int unsigned      FireW      = $clog2(N_SIG + 1),
  localparam int unsigned      IdxW       = $clog2(N_SIG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FireW-1:0]  fire,
  input  logic [N_SIG-1:0]  fire_mask,
  input  logic [N_SIG-1:0]  precap,
  input  logic [N_IN-1:0]   in_en,
  input  logic              clr_flags,
  output logic [N_SIG-1:0]  q,
  output logic [N_SIG-1:0]  excited,
  output logic              hazard,
  output logic [IdxW-1:0]   hazard_idx,
  output logic              illegal,
  output logic              deadlock,
  output logic [CNT_W-1:0]  tcount
);

  localparam int unsigned      QuietW   = $clog2(DL_CYCLES + 1);
  localparam int unsigned      PopW     = $clog2(N_SIG + 1);
  localparam int unsigned      SumW     = CNT_W + PopW;
  localparam logic [N_SIG-1:0] GateMask = {N_SIG{1'b1}} << N_IN;

  logic [N_SIG-1:0] q_w, nxt, en_full, req, req_idx, hit, arm, haz_vec;
  logic [IdxW-1:0]  haz_first;
  logic [PopW-1:0]  pop;
  logic [SumW-1:0]  sum;

  logic              hazard_q, hazard_d;
  logic [IdxW-1:0]   hazard_idx_q, hazard_idx_d;
  logic              illegal_q, illegal_d;
  logic              deadlock_q, deadlock_d;
  logic [CNT_W-1:0]  tcount_q, tcount_d;
  logic [QuietW-1:0] quiet_q, quiet_d;

  // Inputs toggle freely; gates/latches follow the network.
  assign nxt     = (precap & GateMask) | (~q_w & ~GateMask);
  assign en_full = {{(N_SIG - N_IN){1'b1}}, in_en};
  assign excited = (nxt ^ q_w) & en_full;

  always_comb begin
    req_idx = '0;
    for (int unsigned i = 0; i < fire_idle(N_SIG); i++) begin
      if (fire == FireW'(i)) req_idx[i] = 1'b1;
    end
  end

  assign req = MULTI_FIRE ? fire_mask : req_idx;
  assign hit = req & excited;

  for (genvar g = 0; g < int'(N_SIG); g++) begin : g_cell
    localparam sig_kind_e Kind = (g < int'(N_IN)) ? SIG_INPUT : SIG_GATE;
    sync_signal_cell #(
      .INIT_VAL (INIT[g])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .ena   (hit[g]),
      .d     (nxt[g]),
      .arm_d ((Kind != SIG_INPUT) & excited[g] & ~hit[g]),
      .clr   (clr_flags),
      .q     (q_w[g]),
      .arm   (arm[g])
    );
  end

  // A signal armed last cycle that is no longer excited was withdrawn without firing.
  assign haz_vec = arm & ~excited;

  always_comb begin
    haz_first = '0;
    for (int i = int'(N_SIG) - 1; i >= 0; i--) begin
      if (haz_vec[i]) haz_first = IdxW'(i);
    end
  end

  assign pop = PopW'(popcount(MaxSig'(hit)));
  assign sum = SumW'(tcount_q) + SumW'(pop);

  always_comb begin
    illegal_d    = |(req & ~excited);
    hazard_d     = hazard_q | (|haz_vec);
    hazard_idx_d = (!hazard_q && (|haz_vec)) ? haz_first : hazard_idx_q;
    tcount_d     = (|sum[SumW-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    quiet_d      = '0;
    if (excited == '0) begin
      quiet_d = (quiet_q == QuietW'(DL_CYCLES)) ? quiet_q : quiet_q + QuietW'(1);
    end
    deadlock_d   = deadlock_q | (quiet_d == QuietW'(DL_CYCLES));
    if (clr_flags) begin
      hazard_d     = 1'b0;
      hazard_idx_d = '0;
      tcount_d     = '0;
      quiet_d      = '0;
      deadlock_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hazard_q     <= 1'b0;
      hazard_idx_q <= '0;
      illegal_q    <= 1'b0;
      deadlock_q   <= 1'b0;
      tcount_q     <= '0;
      quiet_q      <= '0;
    end else begin
      hazard_q     <= hazard_d;
      hazard_idx_q <= hazard_idx_d;
      illegal_q    <= illegal_d;
      deadlock_q   <= deadlock_d;
      tcount_q     <= tcount_d;
      quiet_q      <= quiet_d;
    end
  end

  assign q          = q_w;
  assign hazard     = hazard_q;
  assign hazard_idx = hazard_idx_q;
  assign illegal    = illegal_q;
  assign deadlock   = deadlock_q;
  assign tcount     = tcount_q;

endmodule

// File: tb/tb_sync_excitation_tracker.sv
// Bench for sync_excitation_tracker: DUT0 fires by index (INIT=A5, CNT_W=16),
// DUT1 fires by mask (INIT=00, CNT_W=2). A reference model predicts each edge;
// predictions are queued when stimulus is applied and popped after the edge.
module tb_sync_excitation_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] precap;
  logic [1:0] in_en;
  logic       clr;
  logic [3:0] fire0;
  logic [7:0] mask1;

  logic [7:0]  q0, exc0, q1, exc1;
  logic        haz0, ill0, dl0, haz1, ill1, dl1;
  logic [2:0]  hidx0, hidx1;
  logic [15:0] tc0;
  logic [1:0]  tc1;

  sync_excitation_tracker #(
    .N_SIG(8), .N_IN(2), .INIT(8'hA5), .MULTI_FIRE(1'b0), .DL_CYCLES(4), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .reset(reset), .fire(fire0), .fire_mask(8'h00), .precap(precap),
    .in_en(in_en), .clr_flags(clr), .q(q0), .excited(exc0), .hazard(haz0),
    .hazard_idx(hidx0), .illegal(ill0), .deadlock(dl0), .tcount(tc0)
  );

  sync_excitation_tracker #(
    .N_SIG(8), .N_IN(2), .INIT(8'h00), .MULTI_FIRE(1'b1), .DL_CYCLES(4), .CNT_W(2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .fire(4'd8), .fire_mask(mask1), .precap(precap),
    .in_en(in_en), .clr_flags(clr), .q(q1), .excited(exc1), .hazard(haz1),
    .hazard_idx(hidx1), .illegal(ill1), .deadlock(dl1), .tcount(tc1)
  );

  typedef struct packed {
    logic [7:0]  q;
    logic [7:0]  arm;
    logic        haz;
    logic [2:0]  idx;
    logic        ill;
    logic        dl;
    logic [15:0] tc;
    logic [3:0]  quiet;
  } mstate_t;

  mstate_t m;
  mstate_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mstate_t m_init(input logic [7:0] init);
    mstate_t s;
    s = '0;
    s.q = init;
    return s;
  endfunction

  function automatic logic [7:0] m_nxt(input mstate_t s, input logic [7:0] pc);
    return {pc[7:2], ~s.q[1:0]};
  endfunction

  function automatic logic [7:0] m_exc(input mstate_t s, input logic [7:0] pc,
                                       input logic [1:0] en);
    return (m_nxt(s, pc) ^ s.q) & {6'h3F, en};
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input logic [7:0] req,
                                     input logic [7:0] pc, input logic [1:0] en,
                                     input logic c, input int unsigned cmax);
    mstate_t n;
    logic [7:0] ex, hit, hz;
    int unsigned t;
    n   = s;
    ex  = m_exc(s, pc, en);
    hit = req & ex;
    hz  = s.arm & ~ex & 8'hFC;
    n.q   = (s.q & ~hit) | (m_nxt(s, pc) & hit);
    n.ill = |(req & ~ex);
    t = int'(s.tc) + $countones(hit);
    if (t > cmax) t = cmax;
    if (c) begin
      n.tc = '0; n.arm = '0; n.haz = 1'b0; n.idx = '0; n.quiet = '0; n.dl = 1'b0;
    end else begin
      n.tc  = 16'(t);
      n.arm = ex & ~hit & 8'hFC;
      if (hz != 8'h00) begin
        if (!s.haz) begin
          for (int i = 7; i >= 0; i--) if (hz[i]) n.idx = 3'(i);
        end
        n.haz = 1'b1;
      end
      if (ex == 8'h00) n.quiet = (s.quiet >= 4) ? 4'd4 : s.quiet + 4'd1;
      else n.quiet = '0;
      if (n.quiet == 4'd4) n.dl = 1'b1;
    end
    return n;
  endfunction

  // Apply current stimulus for one edge on DUT d and compare against the model.
  task automatic step(input int d, input string tag);
    logic [7:0] req;
    #1;
    if (d == 0) req = (fire0 < 4'd8) ? (8'h01 << fire0) : 8'h00;
    else req = mask1;
    check_eq({tag, ":exc"}, (d == 0) ? exc0 : exc1, m_exc(m, precap, in_en));
    sb_q.push_back(m_next(m, req, precap, in_en, clr, (d == 0) ? 65535 : 3));
    @(posedge clk);
    #1;
    m = sb_q.pop_front();
    check_eq({tag, ":q"},    (d == 0) ? q0 : q1, m.q);
    check_eq({tag, ":ill"},  (d == 0) ? ill0 : ill1, m.ill);
    check_eq({tag, ":haz"},  (d == 0) ? haz0 : haz1, m.haz);
    check_eq({tag, ":hidx"}, (d == 0) ? hidx0 : hidx1, m.idx);
    check_eq({tag, ":dl"},   (d == 0) ? dl0 : dl1, m.dl);
    check_eq({tag, ":tc"},   (d == 0) ? tc0 : {14'b0, tc1}, m.tc);
  endtask

  initial begin
    reset = 1'b1; precap = 8'hA5; in_en = 2'b11; clr = 1'b0; fire0 = 4'd8; mask1 = 8'h00;
    m = m_init(8'hA5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_q", q0, 8'hA5);
    check_eq("rst_exc", exc0, 8'h03);
    check_eq("rst_flags", {haz0, ill0, dl0, hidx0}, 6'b0);
    check_eq("rst_tc", tc0, 16'd0);

    fire0 = 4'd0; step(0, "fire0");
    check_eq("fire0_q", q0, 8'hA4);
    check_eq("fire0_tc", tc0, 16'd1);
    fire0 = 4'd8; step(0, "idle");
    check_eq("idle_tc", tc0, 16'd1);

    precap = m.q ^ 8'h20; step(0, "h5_arm");
    precap = m.q;         step(0, "h5_drop");
    check_eq("h5_haz", {haz0, hidx0}, {1'b1, 3'd5});
    precap = m.q ^ 8'h08; step(0, "h3_arm");
    precap = m.q;         step(0, "h3_drop");
    check_eq("h3_idx", hidx0, 3'd5);

    fire0 = 4'd4; step(0, "ill4");
    check_eq("ill4_pulse", {ill0, q0[4], tc0}, {1'b1, 1'b0, 16'd1});
    fire0 = 4'd8; step(0, "ill_end");
    check_eq("ill_end", ill0, 1'b0);

    precap = m.q ^ 8'h40; fire0 = 4'd6; step(0, "fire6");
    fire0 = 4'd8; precap = m.q; in_en = 2'b00;
    for (int k = 0; k < 4; k++) step(0, "quiet");
    check_eq("dl_set", dl0, 1'b1);
    clr = 1'b1; step(0, "clr");
    clr = 1'b0;
    check_eq("clr_flags", {dl0, haz0, tc0}, 18'd0);

    in_en = 2'b11; fire0 = 4'd0; step(0, "pre_rst");
    fire0 = 4'd8;
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_q", q0, 8'hA5);
    check_eq("async_rst_tc", tc0, 16'd0);

    // Mask-fire core, fresh from reset.
    precap = 8'h00;
    @(posedge clk);
    #1 reset = 1'b0;
    m = m_init(8'h00);
    precap = 8'h30; mask1 = 8'b0011_0001; step(1, "multi");
    check_eq("multi_q", q1, 8'h31);
    check_eq("multi_tc", tc1, 2'd3);
    precap = m.q; mask1 = 8'h02; step(1, "sat");
    check_eq("sat_tc", tc1, 2'd3);
    mask1 = 8'h80; step(1, "ill_mask");
    mask1 = 8'h00; step(1, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
